// File: rtl/parity_frame_pkg.sv
// Shared definitions for the parity-frame receiver: FSM state encoding,
// wire-level framing constants, error counter width and a 2-input XNOR
// helper that mirrors the team's xnor_gate cell.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned ERR_CNT_W = 16;

    // Behavioural model of the 2-input xnor_gate cell.
    function automatic logic xnor2(input logic a, input logic b);
        return ~(a ^ b);
    endfunction

endpackage

// File: rtl/parity_frame_rx_acc.sv
// parity_acc: running 1-bit parity accumulator built on the xnor_gate cell.
// The register is seeded with ODD_PAR on clear, so after the data bits it
// already holds the parity bit the transmitter should have sent.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr_i       reseed the accumulator (start of frame)
//   en_i        fold din_i into the accumulator
//   din_i       serial data bit
//   par_o       expected parity bit (registered)
module parity_acc
    import parity_frame_pkg::*;
#(
    parameter bit ODD_PAR = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic din_i,
    output logic par_o
);

    logic acc_q;
    logic acc_d;

    // XOR expressed through the XNOR cell: a ^ b == xnor(a, ~b).
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = ODD_PAR;
        end else if (en_i) begin
            acc_d = xnor2(acc_q, ~din_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= ODD_PAR;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign par_o = acc_q;

endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial receiver for start/data/parity/stop frames.
// Reassembles DATA_W bits (LSB first), checks parity and the stop bit, and
// pulses data_vld for one cycle with the word and its error flags.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bit_vld, sdi    qualified serial input, one frame bit per bit_vld cycle
//   data_out        last received word
//   data_vld        one-cycle pulse when data_out/par_err/frm_err update
//   par_err         received parity bit disagreed with computed parity
//   frm_err         stop bit sampled as 0
//   busy            receiver is inside a frame
//   err_cnt         saturating error-frame count (PARITY_FRAME_RX_ERR_CNT_EN)
module parity_frame_rx
    import parity_frame_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter bit          ODD_PAR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_vld,
    input  logic              sdi,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int unsigned        CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_W - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0]  shift_q;
    logic               perr_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               data_vld_q;
    logic               par_err_q;
    logic               frm_err_q;
    logic               busy_q;

    logic               acc_clr;
    logic               acc_en;
    logic               par_exp;

    // Accumulator is reseeded on the start bit and folds in each data bit.
    assign acc_clr = (state_q == IDLE) && bit_vld && (sdi == START_BIT);
    assign acc_en  = (state_q == DATA) && bit_vld;

    parity_acc #(
        .ODD_PAR (ODD_PAR)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .din_i (sdi),
        .par_o (par_exp)
    );

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic                 frame_bad;

    // Counts frames delivered with either flag set, saturating at all-ones.
    assign frame_bad = perr_q | (sdi != STOP_BIT);
    assign err_cnt_d = (frame_bad && (err_cnt_q != {ERR_CNT_W{1'b1}}))
                     ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (bit_vld && (state_q == STOP)) begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    // Frame FSM; nothing advances on cycles without bit_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_out_q <= '0;
            data_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            data_vld_q <= 1'b0;
            if (bit_vld) begin
                case (state_q)
                    IDLE: begin
                        if (sdi == START_BIT) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q[bit_cnt_q] <= sdi;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PAR;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        perr_q  <= (sdi != par_exp);
                        state_q <= STOP;
                    end
                    STOP: begin
                        // Word is delivered even when flagged.
                        data_out_q <= shift_q;
                        par_err_q  <= perr_q;
                        frm_err_q  <= (sdi != STOP_BIT);
                        data_vld_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out = data_out_q;
    assign data_vld = data_vld_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign busy     = busy_q;

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial parity-frame receiver: the checking end of the team's XNOR parity generators. It accepts a start/data/parity/stop bit stream, one bit per qualified clock. It reassembles the data word, recomputes parity with a running XOR/XNOR reduction, and reports the word with parity-error and framing-error flags. It sits behind any bit-serial link whose transmitter appends a parity bit built from the 2-input XNOR gate chain.

## Interface
- DATA_W, 8, data bits per frame (legal range 1..32)
- ODD_PAR, 0, 0 = even parity (total ones including parity bit even), 1 = odd parity
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bit_vld  input  1  qualifies sdi; one frame bit consumed per clock with bit_vld=1
- sdi  input  1  serial data bit
- data_out  output  DATA_W  last received word, LSB first on the wire
- data_vld  output  1  one-cycle pulse: data_out/par_err/frm_err updated
- par_err  output  1  received parity bit != computed parity
- frm_err  output  1  stop bit sampled as 0
- busy  output  1  high in any state other than IDLE
- err_cnt  output  16  error frame count (present only with PARITY_FRAME_RX_ERR_CNT_EN)

## Operation
- Frame on wire: start (0), DATA_W data bits LSB first, parity bit, stop (1).
- FSM states: IDLE, DATA, PAR, STOP; state and counters advance only on bit_vld=1; bit_vld=0 holds everything.
- IDLE: sdi=0 -> DATA, bit_cnt=0, parity accumulator seeded; sdi=1 -> stay (line idle).
- DATA: shift sdi into data register at position bit_cnt; acc <= acc ^ sdi; after bit DATA_W-1 -> PAR.
- Computed parity: p = acc for ODD_PAR=0; p = ~acc (XNOR reduction) for ODD_PAR=1.
- PAR: capture parity bit, perr <= (sdi != p) -> STOP.
- STOP: latch data_out, par_err=perr, frm_err=~sdi; pulse data_vld; -> IDLE. The word is delivered even on error; flags qualify it.
- No backpressure: a new frame overwrites data_out at its own stop bit.
- bit_cnt width $clog2(DATA_W) (min 1); no wrap beyond DATA_W-1.

## Timing
- Reset values: data_out=0, data_vld=0, par_err=0, frm_err=0, busy=0, err_cnt=0, state=IDLE.
- Latency: data_vld high in the cycle after the clock edge that samples the stop bit; exactly one cycle wide.
- data_out, par_err and frm_err change only with data_vld and are held until the next data_vld.
- busy rises the cycle after the start bit is sampled. It falls in the same cycle data_vld rises.
- Back-to-back: a start bit with bit_vld=1 is accepted in the cycle data_vld is high; no idle bit required.
- Minimum frame: DATA_W+3 bit_vld cycles; arbitrary gaps in bit_vld between bits are legal.
- rst mid-frame: returns to IDLE next cycle, partial word discarded, no data_vld, outputs forced to reset values.
- rst has priority over bit_vld in the same cycle.

## Configuration
- PARITY_FRAME_RX_ERR_CNT_EN defined: err_cnt port present. It increments by 1 on each data_vld with par_err|frm_err. It saturates at 16'hFFFF and is cleared only by rst.
- Not defined: err_cnt port and counter logic absent; all other behaviour identical.

## Structure
- Package parity_frame_pkg: state enum (IDLE, DATA, PAR, STOP), START_BIT=0, STOP_BIT=1, ERR_CNT_W=16.
- Sub-module parity_acc: running 1-bit XOR/XNOR accumulator with clear, enable and ODD_PAR select. It is built from the team's 2-input xnor_gate cell and is reusable by the matching transmitter.
- Top holds FSM, bit counter, shift register, output registers, optional counter.

## Test plan
- DATA_W=8, ODD_PAR=0, continuous bit_vld, frame 0xA5, parity 0, stop 1 -> data_out=0xA5, data_vld one cycle, par_err=0, frm_err=0.
- Same frame with parity bit 1 -> data_out=0xA5, par_err=1, frm_err=0.
- ODD_PAR=1, frame 0x07, parity 0, stop 0 -> data_out=0x07, par_err=0, frm_err=1.
- rst pulsed after 4 data bits of 0x3C, then full frame 0x81 parity 0 -> no data_vld for 0x3C; busy=0 after reset; 0x81 received clean.
- Two back-to-back frames 0x12, 0xFF with random 0-3 cycle bit_vld gaps -> two data_vld pulses, values 0x12 then 0xFF, no errors.
- With PARITY_FRAME_RX_ERR_CNT_EN: 3 bad-parity frames and 1 good frame -> err_cnt=3; rst -> err_cnt=0.
